// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter_pkg: shared definitions for the ALU arbiter slice.
//   DATA_WIDTH  - default operand/result width
//   OP_WIDTH    - default ALUOp width
//   ALUOP_*     - ALUOp encodings understood by the external alu
//   arb_state_e - arbiter FSM state encoding
//   rr_pick()   - round-robin winner given the last-grant pointer
package alu_arbiter_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int OP_WIDTH   = 4;

  localparam logic [3:0] ALUOP_AND = 4'b0000;
  localparam logic [3:0] ALUOP_OR  = 4'b0001;
  localparam logic [3:0] ALUOP_ADD = 4'b0010;
  localparam logic [3:0] ALUOP_SUB = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

  // On a tie, the requester that was not served last wins.
  function automatic logic rr_pick(input logic last_grant);
    return ~last_grant;
  endfunction

endpackage

// File: rtl/alu_arb_pick.sv
// alu_arb_pick: combinational grant selection between two requesters.
//   valid0_i, valid1_i - request valids
//   last_i             - last-grant pointer (requester served most recently)
//   any_o              - at least one request is valid
//   grant_o            - selected requester (0 or 1); meaningful when any_o
// Build option: ALU_ARB_RR_EN selects round-robin on ties; otherwise
// requester 0 has fixed priority and last_i is ignored.
module alu_arb_pick
  import alu_arbiter_pkg::*;
(
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_i,
  output logic any_o,
  output logic grant_o
);

`ifndef ALU_ARB_RR_EN
  // Pointer is still kept by the parent but has no effect on fixed priority.
  logic unused_last_s;
  assign unused_last_s = last_i;
`endif

  // Grant selection: a lone request always wins; ties depend on build mode.
  always_comb begin
    any_o   = valid0_i | valid1_i;
    grant_o = 1'b0;
    if (valid0_i && valid1_i) begin
`ifdef ALU_ARB_RR_EN
      grant_o = rr_pick(last_i);
`else
      grant_o = 1'b0;
`endif
    end else if (valid1_i) begin
      grant_o = 1'b1;
    end else begin
      grant_o = 1'b0;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external alu between two requesters.
//   clk, rst_n                      - clock, async active-low reset
//   reqN_valid/ready/a/b/op (N=0,1) - request channels (ready is combinational)
//   rspN_valid/ready/result/zero    - response channels (registered)
//   alu_a, alu_b, alu_op            - registered operands to the alu
//   alu_result, alu_zero            - alu outputs, captured in EXEC
// One operation in flight: IDLE (accept) -> EXEC (alu driven) -> RESP (hold).
// Build option: ALU_ARB_RR_EN enables round-robin arbitration (see alu_arb_pick).
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DW  = DATA_WIDTH,
  parameter int OPW = OP_WIDTH
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req0_b,
  input  logic [OPW-1:0] req0_op,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req1_b,
  input  logic [OPW-1:0] req1_op,
  output logic           rsp0_valid,
  input  logic           rsp0_ready,
  output logic [DW-1:0]  rsp0_result,
  output logic           rsp0_zero,
  output logic           rsp1_valid,
  input  logic           rsp1_ready,
  output logic [DW-1:0]  rsp1_result,
  output logic           rsp1_zero,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  input  logic [DW-1:0]  alu_result,
  input  logic           alu_zero
);

  arb_state_e     state_q, state_d;
  logic           grant_q, grant_d;
  logic           last_q, last_d;
  logic [DW-1:0]  a_q, a_d;
  logic [DW-1:0]  b_q, b_d;
  logic [OPW-1:0] op_q, op_d;
  logic [DW-1:0]  result_q, result_d;
  logic           zero_q, zero_d;
  logic           rsp0_valid_q, rsp0_valid_d;
  logic           rsp1_valid_q, rsp1_valid_d;
  logic           any_s;
  logic           pick_s;
  logic           rsp_ready_s;

  alu_arb_pick u_pick (
    .valid0_i (req0_valid),
    .valid1_i (req1_valid),
    .last_i   (last_q),
    .any_o    (any_s),
    .grant_o  (pick_s)
  );

  // Request ready: the only combinational input-to-output path (valids + state).
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if ((state_q == ST_IDLE) && any_s) begin
      req0_ready = ~pick_s;
      req1_ready = pick_s;
    end else begin
      req0_ready = 1'b0;
      req1_ready = 1'b0;
    end
  end

  // Consumer handshake of whichever requester owns the current response.
  assign rsp_ready_s = grant_q ? rsp1_ready : rsp0_ready;

  // Next-state and datapath-load logic; registers hold unless a state acts on them.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    result_d     = result_q;
    zero_d       = zero_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (any_s) begin
          grant_d = pick_s;
          a_d     = pick_s ? req1_a  : req0_a;
          b_d     = pick_s ? req1_b  : req0_b;
          op_d    = pick_s ? req1_op : req0_op;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        result_d     = alu_result;
        zero_d       = alu_zero;
        rsp0_valid_d = ~grant_q;
        rsp1_valid_d = grant_q;
        state_d      = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_s) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          last_d       = grant_q;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // FSM and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_q       <= 1'b1;
      a_q          <= {DW{1'b0}};
      b_q          <= {DW{1'b0}};
      op_q         <= {OPW{1'b0}};
      result_q     <= {DW{1'b0}};
      zero_q       <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_q       <= last_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      result_q     <= result_d;
      zero_q       <= zero_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  // Operand registers feed the alu continuously; they only change on accept.
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign alu_op      = op_q;
  assign rsp0_valid  = rsp0_valid_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;
  assign rsp0_zero   = zero_q;
  assign rsp1_zero   = zero_q;

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single `alu` between two requesters: a core execute path (requester 0) and an auxiliary path (requester 1, e.g. address or branch-target computation). It accepts one operation at a time through a valid/ready handshake, arbitrates between the requesters, and drives the ALU operand and opcode inputs from registered copies. It captures `alu_result` and `zero`, then returns them on the granted requester's response channel. The block sits between the requesters and the existing `alu` instance, which stays outside it and unchanged.

## Interface
- `DW`, default `` `DATA_WIDTH `` (from `defs.vh`): operand and result width.
- `OPW`, default 4: ALUOp width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `reqN_valid` in 1 (N=0,1): request valid.
- `reqN_ready` out 1: request accepted this cycle.
- `reqN_a`, `reqN_b` in DW: operands.
- `reqN_op` in OPW: ALUOp (0000 AND, 0001 OR, 0010 ADD, 0110 SUB).
- `rspN_valid` out 1: response valid.
- `rspN_ready` in 1: response consumed.
- `rspN_result` out DW: captured ALU result.
- `rspN_zero` out 1: captured ALU zero flag.
- `alu_a`, `alu_b` out DW: to `alu` operand inputs.
- `alu_op` out OPW: to `alu` ALUOp.
- `alu_result` in DW: from `alu`.
- `alu_zero` in 1: from `alu`.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any `reqN_valid`, pick a grant `g` and assert `req{g}_ready` combinationally. The other ready stays 0.
  - On the clock edge, latch a/b/op into operand registers, latch `g`, and go to EXEC.
- EXEC:
  - `alu_a`/`alu_b`/`alu_op` present the registered operands.
  - On the clock edge, latch `alu_result`/`alu_zero` and go to RESP.
- RESP:
  - Assert `rsp{g}_valid`. The other rsp_valid stays 0.
  - Hold the result until `rsp{g}_ready` is high. Then deassert valid, update the last-grant pointer to `g`, and return to IDLE.
- Both ready outputs are 0 outside IDLE.
- A requester must hold its valid and payload stable until ready. `rspN_result`/`rspN_zero` must be stable while `rspN_valid` is high.
- Opcodes pass through unchecked. Undefined codes produce whatever `alu` yields.
- All arithmetic is done by `alu`. The arbiter never modifies operand or result bits.
- `alu_*` outputs keep their last registered values outside EXEC (no X, no toggling).
- Reset (any cycle, including mid-EXEC/RESP):
  - State goes to IDLE; all operand, result, `alu_*` and `rsp*` registers clear to 0.
  - The last-grant pointer is set to 1, so requester 0 wins first.
  - An in-flight operation is dropped and gets no response.

## Timing
- Accept edge T (valid && ready). The ALU is driven during cycle T+1, and `rsp_valid` rises after edge T+1, visible in cycle T+2.
- Minimum occupancy is 3 cycles per operation, giving one op per 3 cycles with `rsp_ready` held high.
- Response backpressure adds one cycle per stalled cycle. No request is accepted while RESP is stalled.
- `reqN_ready` is combinational from `reqN_valid` and state. There is no other combinational input-to-output path.
- The `alu` path is combinational within the single EXEC cycle.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin. When both requests are valid in IDLE, grant the requester not equal to the last-grant pointer.
- `ALU_ARB_RR_EN` undefined: fixed priority. Requester 0 always wins simultaneous requests; the pointer is still maintained but ignored.
- A single valid request is granted immediately in either mode.

## Structure
- Shared package/`defs.vh` holds:
  - `` `DATA_WIDTH ``.
  - ALUOp encodings (AND, OR, ADD, SUB).
  - FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
- Sub-module `alu_arb_pick`: combinational grant selection from two valids, the last-grant pointer and the macro. The FSM and datapath registers stay in `alu_arbiter`.
- The `alu` is instantiated by the parent, not inside this block.

## Test plan
- Req0 ADD a=4, b=4, rsp0_ready=1 → rsp0_valid in cycle T+2, result=8, zero=0; req1 untouched.
- Req1 SUB a=4, b=4 → rsp1_result=0, rsp1_zero=1; rsp0_valid stays 0 throughout.
- Both valid every cycle (req0 AND 0b0100&0b0100, req1 OR 0b0100|0b0000), RR_EN defined → grants alternate 0,1,0,1, results 0b0100 each. With RR_EN undefined → requester 0 is granted every time and req1 starves.
- rsp0_ready held 0 for 5 cycles after a valid response → result/zero stable, both req_ready stay 0. Then ready=1 → IDLE and the next request is accepted on the following edge.
- rst_n pulsed low during EXEC → all outputs 0 immediately. After release, no stale response appears and req0 is granted first.
- Undefined op 4'b1111 with a=4, b=4 → alu_op=1111 forwarded, the response returns `alu` output unchanged, and the FSM completes normally.
